// File: rtl/rx_arbiter_fifo.sv
// Round-robin capture of NUM_CH UART receiver bytes into one shared, channel-tagged
// first-word-fall-through FIFO, plus sticky per-channel overrun flags.

module rx_ovr_flag (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clr,
  output logic flag
);
  logic flag_q, flag_d;

  // a new overrun in the same cycle as a clear must not be lost
  always_comb flag_d = set | (flag_q & ~clr);

  always_ff @(posedge clk) begin
    if (rst) flag_q <= 1'b0;
    else     flag_q <= flag_d;
  end

  assign flag = flag_q;
endmodule

module rx_arbiter_fifo #(
  parameter  int NUM_CH     = 4,
  parameter  int FIFO_DEPTH = 8,
  localparam int CW         = $clog2(NUM_CH),
  localparam int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [8*NUM_CH-1:0]   rx_data_in,
  input  logic [NUM_CH-1:0]     data_ready_in,
  input  logic [NUM_CH-1:0]     framing_error_in,
  input  logic [NUM_CH-1:0]     overrun_error_in,
  output logic [NUM_CH-1:0]     data_read_out,
  input  logic                  pop,
  output logic                  out_valid,
  output logic [7:0]            out_data,
  output logic [CW-1:0]         out_ch,
  output logic                  out_ferr,
  output logic [AW:0]           fifo_count,
  output logic                  fifo_full,
  input  logic                  clear_flags,
  output logic [NUM_CH-1:0]     ovr_flag
);
  localparam int CNTW = AW + 1;

  typedef enum logic [1:0] {IDLE, CAPTURE, RELEASE} state_e;

  typedef struct packed {
    logic [CW-1:0] ch;
    logic          ferr;
    logic [7:0]    data;
  } entry_t;

  state_e          state_q, state_d;
  logic [CW-1:0]   grant_q, grant_d;
  logic [CW-1:0]   last_grant_q, last_grant_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  entry_t          mem_q [FIFO_DEPTH];

  logic            pick_found;
  logic [CW-1:0]   pick_ch;
  logic [CW-1:0]   cand;
  int              idx;
  logic            wr_en;
  logic            do_pop;
  entry_t          wr_entry;
  entry_t          head;

  // rotating-priority search starting just after the last served channel
  always_comb begin
    pick_found = 1'b0;
    pick_ch    = last_grant_q;
    cand       = '0;
    idx        = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = int'(last_grant_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      cand = CW'(idx);
      if (!pick_found && data_ready_in[cand]) begin
        pick_found = 1'b1;
        pick_ch    = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    wr_en         = 1'b0;
    data_read_out = '0;
    case (state_q)
      IDLE: begin
        if (pick_found && !fifo_full) begin
          grant_d = pick_ch;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        wr_en                  = 1'b1;
        data_read_out[grant_q] = 1'b1;
        last_grant_d           = grant_q;
        state_d                = RELEASE;
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= CW'(NUM_CH - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // FIFO bookkeeping; a write never targets a full FIFO because fullness gates IDLE
  always_comb begin
    do_pop        = pop && (count_q != '0);
    wr_entry.ch   = grant_q;
    wr_entry.ferr = framing_error_in[grant_q];
    wr_entry.data = rx_data_in[8*grant_q +: 8];
    wr_ptr_d      = wr_ptr_q + AW'(wr_en);
    rd_ptr_d      = rd_ptr_q + AW'(do_pop);
    count_d       = count_q + CNTW'(wr_en) - CNTW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign head       = mem_q[rd_ptr_q];
  assign out_data   = head.data;
  assign out_ch     = head.ch;
  assign out_ferr   = head.ferr;
  assign out_valid  = (count_q != '0);
  assign fifo_full  = (count_q == CNTW'(FIFO_DEPTH));
  assign fifo_count = count_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ovr
    rx_ovr_flag u_flag (
      .clk  (clk),
      .rst  (rst),
      .set  (overrun_error_in[i]),
      .clr  (clear_flags),
      .flag (ovr_flag[i])
    );
  end
endmodule

// File: tb/tb_rx_arbiter_fifo.sv
// Randomized + directed bench for rx_arbiter_fifo: a transaction-level model predicts
// every cycle's outputs into a queue that a negedge monitor checks against the DUT.
module tb_rx_arbiter_fifo;
  localparam int NUM_CH = 4;
  localparam int DEPTH  = 8;
  localparam int CW     = 2;
  localparam int AW     = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [8*NUM_CH-1:0]   rx_data_in;
  logic [NUM_CH-1:0]     data_ready_in;
  logic [NUM_CH-1:0]     framing_error_in;
  logic [NUM_CH-1:0]     overrun_error_in;
  logic [NUM_CH-1:0]     data_read_out;
  logic                  pop;
  logic                  out_valid;
  logic [7:0]            out_data;
  logic [CW-1:0]         out_ch;
  logic                  out_ferr;
  logic [AW:0]           fifo_count;
  logic                  fifo_full;
  logic                  clear_flags;
  logic [NUM_CH-1:0]     ovr_flag;

  rx_arbiter_fifo #(.NUM_CH(NUM_CH), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx_data_in(rx_data_in), .data_ready_in(data_ready_in),
    .framing_error_in(framing_error_in), .overrun_error_in(overrun_error_in),
    .data_read_out(data_read_out), .pop(pop), .out_valid(out_valid),
    .out_data(out_data), .out_ch(out_ch), .out_ferr(out_ferr),
    .fifo_count(fifo_count), .fifo_full(fifo_full), .clear_flags(clear_flags),
    .ovr_flag(ovr_flag)
  );

  always #5 clk = ~clk;

  typedef struct { int ch; logic fe; logic [7:0] d; } ent_t;
  typedef struct {
    logic [NUM_CH-1:0] dro;
    int                cnt;
    logic              hv;
    int                hch;
    logic              hfe;
    logic [7:0]        hd;
    logic [NUM_CH-1:0] ovr;
  } rec_t;

  int   n_chk = 0;
  int   n_pass = 0;
  ent_t mq[$];
  rec_t recs[$];
  rec_t cur;
  int   m_last = NUM_CH - 1;
  int   m_busy = 0;
  int   m_pend = 0;
  logic [NUM_CH-1:0] m_ovr = '0;

  logic [8:0] rxq[NUM_CH][$];
  int   gap[NUM_CH];
  int   pop_rate = 0, ovr_rate = 0, clr_rate = 0;
  bit   rr_log = 0;
  int   glog[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Reference: consumes the inputs that were applied during the cycle that just ended.
  // Rules: a grant is taken only when the arbiter is free and the queue has room,
  // captured the next cycle, followed by one idle holdoff cycle.
  function automatic void model_step();
    int  sz;
    bit  gr;
    int  g;
    int  c;
    if (rst) begin
      mq.delete();
      m_last = NUM_CH - 1;
      m_busy = 0;
      m_ovr  = '0;
      return;
    end
    sz = mq.size();
    gr = 0;
    g  = 0;
    if (m_busy == 0 && sz < DEPTH)
      for (int k = 1; k <= NUM_CH; k++) begin
        c = (m_last + k) % NUM_CH;
        if (!gr && data_ready_in[c]) begin gr = 1; g = c; end
      end
    if (pop && sz > 0) void'(mq.pop_front());
    if (m_busy == 2) begin
      mq.push_back('{m_pend, framing_error_in[m_pend], rx_data_in[8*m_pend +: 8]});
      m_last = m_pend;
    end
    m_ovr = (clear_flags ? '0 : m_ovr) | overrun_error_in;
    if (m_busy > 0) m_busy--;
    else if (gr) begin m_busy = 2; m_pend = g; end
  endfunction

  function automatic void publish();
    rec_t r;
    r.dro = '0;
    if (m_busy == 2) r.dro[m_pend] = 1'b1;
    r.cnt = mq.size();
    r.hv  = (mq.size() > 0);
    r.hch = r.hv ? mq[0].ch : 0;
    r.hfe = r.hv ? mq[0].fe : 1'b0;
    r.hd  = r.hv ? mq[0].d : 8'h00;
    r.ovr = m_ovr;
    recs.push_back(r);
  endfunction

  // Receiver model: drops ready the cycle after a read, reloads two cycles later.
  function automatic void rx_update(input logic [NUM_CH-1:0] seen);
    logic [8:0] v;
    for (int i = 0; i < NUM_CH; i++) begin
      if (seen[i] === 1'b1) begin
        data_ready_in[i]     = 1'b0;
        rx_data_in[8*i +: 8] = 8'($urandom);
        gap[i]               = 2;
      end else if (!data_ready_in[i]) begin
        if (gap[i] > 0) gap[i]--;
        else if (rxq[i].size() > 0) begin
          v = rxq[i].pop_front();
          rx_data_in[8*i +: 8] = v[7:0];
          framing_error_in[i]  = v[8];
          data_ready_in[i]     = 1'b1;
        end
      end
    end
  endfunction

  task automatic step();
    logic [NUM_CH-1:0] seen;
    seen = data_read_out;
    @(posedge clk); #1;
    model_step();
    publish();
    pop         = ($urandom_range(0, 99) < pop_rate);
    clear_flags = ($urandom_range(0, 99) < clr_rate);
    for (int i = 0; i < NUM_CH; i++) overrun_error_in[i] = ($urandom_range(0, 99) < ovr_rate);
    rx_update(seen);
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
  endtask

  task automatic wait_capture(output bit found);
    found = 0;
    for (int i = 0; i < 15 && !found; i++) begin
      step();
      if (m_busy == 2) found = 1;
    end
  endtask

  always @(negedge clk) begin
    if (recs.size() > 0) begin
      cur = recs.pop_front();
      chk("data_read_out", data_read_out, cur.dro);
      chk("fifo_count", fifo_count, cur.cnt);
      chk("out_valid", out_valid, cur.hv);
      chk("fifo_full", fifo_full, cur.cnt == DEPTH);
      chk("ovr_flag", ovr_flag, cur.ovr);
      if (cur.hv) begin
        chk("out_data", out_data, cur.hd);
        chk("out_ch", out_ch, cur.hch);
        chk("out_ferr", out_ferr, cur.hfe);
      end
    end
    if (rr_log)
      for (int i = 0; i < NUM_CH; i++) if (data_read_out[i] === 1'b1) glog.push_back(i);
  end

  initial begin
    bit found;
    rst = 1'b1; pop = 0; clear_flags = 0; overrun_error_in = '0;
    data_ready_in = '0; rx_data_in = '0; framing_error_in = '0;
    for (int i = 0; i < NUM_CH; i++) gap[i] = 0;
    repeat (3) step();
    rst = 1'b0;

    // single byte on channel 2
    rxq[2].push_back({1'b0, 8'hA5});
    repeat (6) step();
    chk("single_cnt", fifo_count, 1);
    chk("single_data", out_data, 8'hA5);
    chk("single_ch", out_ch, 2);
    pop = 1; step();
    chk("single_pop", fifo_count, 0);

    // round-robin with all channels continuously busy
    do_reset();
    pop_rate = 100;
    rr_log = 1;
    for (int c = 0; c < NUM_CH; c++)
      for (int j = 0; j < 6; j++) rxq[c].push_back({1'b0, 8'($urandom)});
    repeat (100) step();
    rr_log = 0;
    chk("rr_grants", glog.size(), 24);
    for (int j = 0; j < 24 && j < glog.size(); j++) chk("rr_order", glog[j], j % NUM_CH);

    // fill to full from channel 1 with no consumer
    pop_rate = 0;
    for (int v = 8'h10; v <= 8'h19; v++) rxq[1].push_back({1'b0, 8'(v)});
    repeat (40) step();
    chk("full_flag", fifo_full, 1);
    chk("full_cnt", fifo_count, 8);
    chk("full_no_read", data_read_out, 0);
    overrun_error_in[1] = 1'b1; step();
    chk("ovr_set", ovr_flag, 4'b0010);
    pop = 1; step();
    repeat (8) step();
    chk("full_refill", fifo_count, 8);
    pop_rate = 100; repeat (30) step(); pop_rate = 0;

    // framing error tag
    rxq[3].push_back({1'b1, 8'h7E});
    repeat (6) step();
    chk("ferr_tag", out_ferr, 1);
    chk("ferr_ch", out_ch, 3);
    chk("ferr_data", out_data, 8'h7E);
    pop = 1; step();

    // pop coinciding with a capture write at count 3
    for (int v = 8'h31; v <= 8'h33; v++) rxq[0].push_back({1'b0, 8'(v)});
    repeat (15) step();
    chk("pre_cnt3", fifo_count, 3);
    rxq[0].push_back({1'b0, 8'h34});
    wait_capture(found);
    chk("capture_seen", found, 1);
    pop = 1; step();
    chk("pop_wr_cnt", fifo_count, 3);

    // clear and set in the same cycle
    clear_flags = 1; overrun_error_in[0] = 1'b1; step();
    chk("clr_set_win", ovr_flag, 4'b0001);

    // pop on empty
    pop_rate = 100; repeat (15) step(); pop_rate = 0;
    pop = 1; step();
    chk("empty_pop_cnt", fifo_count, 0);
    chk("empty_pop_valid", out_valid, 0);

    // reset during CAPTURE
    rxq[1].push_back({1'b0, 8'h55});
    wait_capture(found);
    chk("rst_capture_seen", found, 1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_dro", data_read_out, 0);
    chk("rst_cnt", fifo_count, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ovr", ovr_flag, 0);
    rxq[0].push_back({1'b0, 8'hC0});
    rxq[2].push_back({1'b0, 8'hC2});
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      step();
      if (data_read_out !== '0) found = 1;
    end
    chk("first_grant_after_rst", data_read_out, 4'b0001);
    pop_rate = 100; repeat (12) step();

    // randomized traffic
    pop_rate = 40; ovr_rate = 3; clr_rate = 2;
    for (int n = 0; n < 500; n++) begin
      for (int c = 0; c < NUM_CH; c++)
        if (rxq[c].size() == 0 && $urandom_range(0, 99) < 20)
          rxq[c].push_back(9'($urandom));
      step();
    end
    ovr_rate = 0; clr_rate = 0; pop_rate = 100;
    repeat (60) step();
    pop_rate = 0;
    repeat (3) step();
    for (int i = 0; i < 10 && recs.size() > 0; i++) @(negedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rx_arbiter_fifo.md
# rx_arbiter_fifo

Shares one receive FIFO among NUM_CH UART receive blocks. Each receiver's rx_data / data_ready / error outputs feed this block. A round-robin arbiter picks one pending channel, captures its byte and its framing_error status into a tagged FIFO entry, and pulses that channel's data_read to release its buffer. Downstream logic pops tagged bytes through a first-word-fall-through interface and reads sticky per-channel overrun flags.

## Interface
- NUM_CH, 4: number of receiver channels, 2..8.
- FIFO_DEPTH, 8: entries; power of 2, ≥2.
- CW = $clog2(NUM_CH); AW = $clog2(FIFO_DEPTH) (derived, localparam).

- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- rx_data_in  in  8*NUM_CH  channel i byte at bits [8i+7:8i].
- data_ready_in  in  NUM_CH  channel i holds an unread byte.
- framing_error_in  in  NUM_CH  channel i framing error status.
- overrun_error_in  in  NUM_CH  channel i overrun indication.
- data_read_out  out  NUM_CH  one-cycle release pulse to channel i.
- pop  in  1  consumer accepts head entry.
- out_valid  out  1  FIFO non-empty.
- out_data  out  8  head byte.
- out_ch  out  CW  head entry source channel.
- out_ferr  out  1  head entry framing error tag.
- fifo_count  out  AW+1  occupancy, 0..FIFO_DEPTH.
- fifo_full  out  1  fifo_count == FIFO_DEPTH.
- clear_flags  in  1  clears ovr_flag.
- ovr_flag  out  NUM_CH  sticky overrun per channel.

## Operation
- FSM states: IDLE, CAPTURE, RELEASE.
- IDLE: if (|data_ready_in) && !fifo_full, select grant = first i with data_ready_in[i] set, searching from (last_grant+1) mod NUM_CH upward with wrap. Register grant, go CAPTURE. Otherwise stay in IDLE.
- CAPTURE: write {grant, framing_error_in[grant], rx_data_in[grant]} at the tail. Assert data_read_out[grant] for this cycle only. Set last_grant = grant. Go RELEASE.
- RELEASE: one-cycle holdoff so the receiver's registered data_ready can drop. All data_read_out = 0. Go IDLE.
- At most one data_read_out bit is high at any time.
- Full FIFO: the arbiter holds in IDLE and reads nothing. The receiver keeps its byte and may overrun; that overrun is recorded in ovr_flag.
- CAPTURE never sees a full FIFO: fullness is checked in IDLE, and only pop can change occupancy between IDLE and CAPTURE.
- FIFO: circular buffer with AW-bit read and write pointers that wrap modulo FIFO_DEPTH.
  - pop while empty is ignored.
  - A write and a pop in the same cycle leave fifo_count unchanged.
  - out_data, out_ch and out_ferr show the head entry combinationally from storage. They are don't-care when out_valid = 0.
- ovr_flag[i] sets on any cycle where overrun_error_in[i] = 1. clear_flags clears all bits. If set and clear happen in the same cycle, set wins for that channel.
- Reset values:
  - State IDLE; last_grant = NUM_CH-1, so channel 0 wins first.
  - Pointers 0; fifo_count 0; out_valid 0; fifo_full 0.
  - data_read_out 0; ovr_flag 0.
- Reset mid-operation: rst asserted in CAPTURE or RELEASE forces IDLE next cycle. A data_read_out pulse already driven is not repeated. The FIFO is emptied and its contents discarded.

## Timing
- data_ready_in[i] sampled high in IDLE at cycle t:
  - t+1: CAPTURE, data_read_out[i] = 1, entry written.
  - t+2: out_valid = 1 (if FIFO was empty), state RELEASE.
  - t+3: IDLE, next grant possible.
- Sustained throughput is one byte per 3 cycles.
- pop at cycle t updates the head and fifo_count at t+1.
- fifo_full and out_valid are registered-state-derived, with no combinational path from pop.
- ovr_flag updates one cycle after overrun_error_in or clear_flags.

## Test plan
- Single byte: ch2 data_ready_in=1, rx_data=8'hA5, ferr=0.
  - Expect data_read_out=4'b0100 for exactly 1 cycle.
  - Then out_valid=1, out_data=A5, out_ch=2, out_ferr=0, fifo_count=1.
  - Then pop gives fifo_count=0.
- Round-robin: all 4 channels held ready (receiver model drops ready 1 cycle after read, reloads 2 cycles later).
  - Grant order must be 0,1,2,3,0,1...
  - No channel may be granted twice while another is pending.
- Full FIFO: no pops, channel 1 streams 10 bytes 0x10..0x19.
  - fifo_full=1 after 8 entries and data_read_out stays 0.
  - Inject overrun_error_in[1]=1; expect ovr_flag=4'b0010.
  - One pop gives exactly one more capture (0x18).
- Framing tag: ch3 byte 8'h7E with framing_error_in[3]=1; expect head entry out_ferr=1, out_ch=3.
- Simultaneous events:
  - pop on the same cycle as a CAPTURE write with count=3: count stays 3.
  - clear_flags with overrun_error_in[0]=1 in the same cycle: ovr_flag[0] remains 1.
  - pop on an empty FIFO: no change.
- Reset mid-op: assert rst in the CAPTURE cycle.
  - Next cycle: data_read_out=0, fifo_count=0, out_valid=0, ovr_flag=0.
  - The first grant after reset goes to channel 0 if it is ready.
